motion_sequencer: RTL and testbench



---
 rtl/motion_pkg.sv | 27 ++
 rtl/cycle_timer.sv | 31 +++
 rtl/motion_sequencer.sv | 151 +++++++++++++++
 tb/tb_motion_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared status codes, FSM state encoding and the state-to-command mapping
// for the motion sequencer.
package motion_pkg;

    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_FWD   = 2'b11;
    localparam logic [1:0] ST_RIGHT = 2'b01;
    localparam logic [1:0] ST_LEFT  = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEAD  = 3'd1;
    localparam logic [2:0] S_FWD   = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    // Motor command driven while sitting in a given state.
    function automatic logic [1:0] status_code(input logic [2:0] state, input logic turn_dir);
        logic [1:0] code;
        code = ST_STOP;
        if (state == S_FWD)
            code = ST_FWD;
        else if (state == S_TURN)
            code = turn_dir ? ST_LEFT : ST_RIGHT;
        return code;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used for the dead-time and pivot intervals.
// Counts down to zero and parks there; clear has priority over load.
module cycle_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_value <= '0;
        else if (i_clr)
            r_value <= '0;
        else if (i_load)
            r_value <= i_load_val;
        else if (r_value != '0)
            r_value <= r_value - 1'b1;
    end

    assign o_value = r_value;
    assign o_done  = (r_value == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Drive sequencer: turns ultrasonic distance samples into the 2-bit motor
// command for the H-bridge, with dead-time on every motion change and a watchdog.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int DIST_W      = 9,
    parameter int THRESH_CM   = 20,
    parameter int HYST_CM     = 5,
    parameter int DEAD_CYC    = 50000,
    parameter int TURN_CYC    = 25000000,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIST_W-1:0] dist_cm,
    input  logic              dist_valid,
    output logic [1:0]        status,
    output logic              obstacle,
    output logic              fault
);

    localparam logic [DIST_W:0]  THR_CM  = (DIST_W+1)'(THRESH_CM);
    localparam logic [DIST_W:0]  RES_CM  = THR_CM + (DIST_W+1)'(HYST_CM);
    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_target;
    logic             r_turn_dir;
    logic [1:0]       r_status;
    logic             r_obstacle;
    logic             r_fault;
    logic [CNT_W-1:0] r_wd_cnt;

    logic [2:0]       w_state_nx;
    logic [2:0]       w_target_nx;
    logic             w_dir_nx;
    logic             w_tmr_clr;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic [CNT_W-1:0] w_tmr_value;
    logic             w_tmr_done;
    logic [DIST_W:0]  w_dist_ext;
    logic             w_clear;
    logic             w_resume;
    logic             w_wd_expire;

    assign w_dist_ext  = {1'b0, dist_cm};
    assign w_clear     = dist_valid && (w_dist_ext >= THR_CM);
    assign w_resume    = dist_valid && (w_dist_ext >= RES_CM);
    // A strobe arriving on the expiry cycle wins over the timeout.
    assign w_wd_expire = enable && !dist_valid && (r_wd_cnt == WD_LAST);

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_value    (w_tmr_value),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_dir_nx    = r_turn_dir;
        w_tmr_clr   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        if (!enable || w_wd_expire) begin
            w_state_nx = S_IDLE;
            w_tmr_clr  = (w_tmr_value != '0);
        end else begin
            case (r_state)
                S_IDLE: if (w_clear) begin
                    w_state_nx  = S_DEAD;
                    w_target_nx = S_FWD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = DEAD_LD;
                end
                S_DEAD: if (w_tmr_done) begin
                    w_state_nx = r_target;
                    if (r_target == S_TURN) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TURN_LD;
                    end
                end
                S_FWD: if (dist_valid && !w_clear) begin
                    w_state_nx  = S_DEAD;
                    w_target_nx = S_TURN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = DEAD_LD;
                end
                S_TURN: if (w_tmr_done)
                    w_state_nx = S_CHECK;
                // Already stopped here, so both exits skip the dead-time.
                S_CHECK: if (w_resume) begin
                    w_state_nx = S_FWD;
                    w_dir_nx   = !r_turn_dir;
                end else if (dist_valid) begin
                    w_state_nx = S_TURN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TURN_LD;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_target   <= S_IDLE;
            r_turn_dir <= 1'b0;
            r_status   <= ST_STOP;
        end else begin
            r_state    <= w_state_nx;
            r_target   <= w_target_nx;
            r_turn_dir <= w_dir_nx;
            r_status   <= status_code(w_state_nx, w_dir_nx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt   <= '0;
            r_fault    <= 1'b0;
            r_obstacle <= 1'b0;
        end else begin
            if (!enable || dist_valid || w_wd_expire)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + 1'b1;
            if (dist_valid)
                r_fault <= 1'b0;
            else if (w_wd_expire)
                r_fault <= 1'b1;
            if (dist_valid)
                r_obstacle <= (w_dist_ext < THR_CM);
        end
    end

    assign status   = r_status;
    assign obstacle = r_obstacle;
    assign fault    = r_fault;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer using shortened timing parameters;
// expected command sequences are hand-derived cycle by cycle.
module tb_motion_sequencer;

    localparam int DIST_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [DIST_W-1:0] dist_cm = '0;
    logic              dist_valid = 1'b0;
    logic [1:0]        status;
    logic              obstacle;
    logic              fault;

    int n_tests = 0;
    int n_fail  = 0;

    motion_sequencer #(
        .DIST_W      (DIST_W),
        .THRESH_CM   (20),
        .HYST_CM     (5),
        .DEAD_CYC    (4),
        .TURN_CYC    (16),
        .TIMEOUT_CYC (64),
        .CNT_W       (25)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .status     (status),
        .obstacle   (obstacle),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int d);
        dist_cm    = DIST_W'(d);
        dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
    endtask

    // Checks the current status, then advances; repeated n times.
    task automatic expect_run(input string tag, input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, status, code);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_status", status, 2'b00);
        check("rst_obstacle", obstacle, 1'b0);
        check("rst_fault", fault, 1'b0);
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        check("idle_hold", status, 2'b00);

        strobe(100);
        check("start_obst", obstacle, 1'b0);
        expect_run("start_dead", 2'b00, 4);
        check("start_fwd", status, 2'b11);

        strobe(20);
        check("thresh_eq_fwd", status, 2'b11);
        check("thresh_eq_obst", obstacle, 1'b0);
        tick();
        check("thresh_eq_fwd2", status, 2'b11);

        strobe(19);
        check("obst_flag", obstacle, 1'b1);
        expect_run("obst_dead", 2'b00, 4);
        expect_run("obst_right", 2'b01, 16);
        check("obst_check", status, 2'b00);

        strobe(22);
        expect_run("hyst_right", 2'b01, 16);
        check("hyst_check", status, 2'b00);

        strobe(25);
        check("resume_fwd", status, 2'b11);
        check("resume_obst", obstacle, 1'b0);

        strobe(5);
        expect_run("left_dead", 2'b00, 4);
        check("left_turn", status, 2'b10);
        tick();
        tick();
        check("left_turn2", status, 2'b10);

        enable = 1'b0;
        tick();
        check("dis_stop", status, 2'b00);
        tick();
        strobe(100);
        check("dis_stay", status, 2'b00);
        check("dis_obst", obstacle, 1'b0);
        tick();
        tick();
        check("dis_stay2", status, 2'b00);
        enable = 1'b1;
        tick();
        check("reen_idle", status, 2'b00);
        tick();
        check("reen_idle2", status, 2'b00);
        strobe(100);
        expect_run("reen_dead", 2'b00, 4);
        check("reen_fwd", status, 2'b11);

        repeat (59) tick();
        check("wd_pre_fault", fault, 1'b0);
        check("wd_pre_status", status, 2'b11);
        tick();
        check("wd_fault", fault, 1'b1);
        check("wd_stop", status, 2'b00);
        tick();
        check("wd_idle", status, 2'b00);
        strobe(100);
        check("wd_clear", fault, 1'b0);
        expect_run("wd_dead", 2'b00, 4);
        check("wd_fwd", status, 2'b11);

        repeat (59) tick();
        strobe(100);
        check("wd_race_fault", fault, 1'b0);
        check("wd_race_fwd", status, 2'b11);
        tick();
        check("wd_race_fault2", fault, 1'b0);
        check("wd_race_fwd2", status, 2'b11);

        strobe(10);
        expect_run("rst_dead", 2'b00, 4);
        check("rst_turn", status, 2'b10);
        check("rst_turn_obst", obstacle, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_status", status, 2'b00);
        check("async_obst", obstacle, 1'b0);
        check("async_fault", fault, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_idle", status, 2'b00);
        strobe(100);
        expect_run("post_rst_dead", 2'b00, 4);
        check("post_rst_fwd", status, 2'b11);
        strobe(3);
        expect_run("post_rst_tdead", 2'b00, 4);
        check("post_rst_right", status, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
